imem_boot_loader: RTL



---
 rtl/imem_boot_loader_pkg.sv | 18 +
 rtl/imem_boot_loader_packer.sv | 39 +++
 rtl/imem_boot_loader.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/imem_boot_loader_pkg.sv
// rtl/imem_boot_loader_pkg.sv - shared types and constants for the instruction-memory boot loader
package imem_boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_WRITE,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_SHIFT     = 2;
    localparam int DEF_MEM_DEPTH  = 256;
    localparam int CNT_W          = $clog2(DEF_MEM_DEPTH + 1);

endpackage

// File: rtl/imem_boot_loader_packer.sv
// rtl/imem_boot_loader_packer.sv - little-endian byte-to-word packer shared by header and data phases
module le_byte_packer
    import imem_boot_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic [31:0] word,
    output logic        word_valid
);

    localparam int IDX_W = $clog2(BYTES_PER_WORD);

    logic [IDX_W-1:0] byte_idx;
    logic [31:0]      shreg;

    // The incoming byte is merged combinationally so the full word is visible on the 4th transfer.
    always_comb begin
        word = shreg;
        if (in_valid) begin
            word[{byte_idx, 3'b000} +: 8] = in_data;
        end
    end

    assign word_valid = in_valid && (byte_idx == IDX_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            byte_idx <= '0;
            shreg    <= '0;
        end else if (in_valid) begin
            byte_idx <= byte_idx + 1'b1;
            shreg    <= word;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - loads a length-prefixed byte stream into instruction memory while holding the CPU
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int DATA      = 32,
    parameter int ADDR      = 32,
    parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           load_start,
    input  logic                           s_valid,
    input  logic [7:0]                     s_data,
    output logic                           s_ready,
    input  logic [ADDR-1:0]                cpu_pc,
    output logic [ADDR-1:0]                imem_addr,
    output logic                           imem_we,
    output logic [DATA-1:0]                imem_wd,
    output logic                           cpu_hold,
    output logic                           load_done,
    output logic                           load_err,
    output logic [$clog2(MEM_DEPTH+1)-1:0] words_loaded
);

    localparam int LW = $clog2(MEM_DEPTH + 1);

    state_t          state, state_next;
    logic            xfer;
    logic            pk_clear;
    logic            pk_valid;
    logic [31:0]     pk_word;
    logic [LW-1:0]   word_idx;
    logic [LW-1:0]   count;
    logic [ADDR-1:0] idx_addr;

    assign xfer     = s_valid && s_ready;
    assign idx_addr = ADDR'(word_idx) << WORD_SHIFT;

    le_byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (pk_clear),
        .in_valid   (xfer),
        .in_data    (s_data),
        .word       (pk_word),
        .word_valid (pk_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        cpu_hold   = 1'b0;
        load_done  = 1'b0;
        imem_we    = 1'b0;
        imem_addr  = cpu_pc;
        pk_clear   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (load_start) begin
                    state_next = ST_HDR;
                    pk_clear   = 1'b1;
                end
            end
            ST_HDR: begin
                s_ready   = 1'b1;
                cpu_hold  = 1'b1;
                imem_addr = idx_addr;
                // Compare the whole 32-bit count so stray high bytes cannot alias into range.
                if (pk_valid) begin
                    if (pk_word == 32'd0) begin
                        state_next = ST_DONE;
                    end else if (pk_word > 32'(MEM_DEPTH)) begin
                        state_next = ST_ERR;
                    end else begin
                        state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                s_ready   = 1'b1;
                cpu_hold  = 1'b1;
                imem_addr = idx_addr;
                if (pk_valid) begin
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                cpu_hold   = 1'b1;
                imem_we    = 1'b1;
                imem_addr  = idx_addr;
                state_next = (LW'(word_idx + 1'b1) == count) ? ST_DONE : ST_DATA;
            end
            ST_DONE: begin
                load_done  = 1'b1;
                state_next = ST_IDLE;
            end
            ST_ERR: begin
                cpu_hold  = 1'b1;
                imem_addr = idx_addr;
                if (load_start) begin
                    state_next = ST_HDR;
                    pk_clear   = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_idx     <= '0;
            count        <= '0;
            words_loaded <= '0;
            imem_wd      <= '0;
            load_err     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_ERR: begin
                    if (load_start) begin
                        word_idx     <= '0;
                        words_loaded <= '0;
                        load_err     <= 1'b0;
                    end
                end
                ST_HDR: begin
                    if (pk_valid) begin
                        count <= pk_word[LW-1:0];
                        if (state_next == ST_ERR) begin
                            load_err <= 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (pk_valid) begin
                        imem_wd <= DATA'(pk_word);
                    end
                end
                ST_WRITE: begin
                    word_idx     <= word_idx + 1'b1;
                    words_loaded <= words_loaded + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
